// File: rtl/video_pkg.sv
// Shared screen constants, pixel defaults and clear FSM state type
// for the video window buffer.
package video_pkg;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int COORD_W        =
        $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);
    localparam int DATA_WIDTH_DEF = 3;
    localparam int BG_COLOR_DEF   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/video_window_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write returns the pre-write word.
module video_window_ram #(
    parameter int DW    = 3,
    parameter int DEPTH = 10000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/video_window_buffer.sv
// Screen-addressed pixel window with 1-cycle reads and discard of
// off-window writes; optional bulk clear under WINDOW_CLEAR_EN.
module video_window_buffer
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = COORD_W,
    parameter int WIN_ROWS   = 100,
    parameter int WIN_COLS   = 100,
    parameter int ORIGIN_ROW = 190,
    parameter int ORIGIN_COL = 270,
    parameter int BG_COLOR   = BG_COLOR_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  iReadValid,
    input  logic [ADDR_WIDTH-1:0] iReadRow,
    input  logic [ADDR_WIDTH-1:0] iReadCol,
    output logic                  oRGBValid,
    output logic [DATA_WIDTH-1:0] oRGB,
    input  logic                  iWriteValid,
    input  logic [ADDR_WIDTH-1:0] iWriteRow,
    input  logic [ADDR_WIDTH-1:0] iWriteCol,
    input  logic [DATA_WIDTH-1:0] iRGB,
    output logic                  oWriteReady,
    input  logic                  iClear,
    output logic                  oBusy
);

    localparam int LP_DEPTH = WIN_ROWS * WIN_COLS;
    localparam int LP_AW    = $clog2(LP_DEPTH);
    localparam logic [DATA_WIDTH-1:0] LP_BG = DATA_WIDTH'(BG_COLOR);

    // Coordinates are widened to int so no bits are lost in the compare
    function automatic logic in_win(
        input logic [ADDR_WIDTH-1:0] row,
        input logic [ADDR_WIDTH-1:0] col
    );
        return (int'(row) >= ORIGIN_ROW) &&
               (int'(row) <  ORIGIN_ROW + WIN_ROWS) &&
               (int'(col) >= ORIGIN_COL) &&
               (int'(col) <  ORIGIN_COL + WIN_COLS);
    endfunction

    function automatic logic [LP_AW-1:0] lin_addr(
        input logic [ADDR_WIDTH-1:0] row,
        input logic [ADDR_WIDTH-1:0] col
    );
        int l;
        l = (int'(row) - ORIGIN_ROW) * WIN_COLS +
            (int'(col) - ORIGIN_COL);
        return LP_AW'(l);
    endfunction

    logic                  w_rd_in;
    logic [LP_AW-1:0]      w_rd_addr;
    logic                  w_wr_in;
    logic [LP_AW-1:0]      w_wr_addr;
    logic                  w_user_we;
    logic                  w_clr_we;
    logic [LP_AW-1:0]      w_clr_addr;
    logic                  w_ram_we;
    logic [LP_AW-1:0]      w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [DATA_WIDTH-1:0] w_rd_pix;

    logic                  r_rd_valid;
    logic                  r_rd_in;
    logic [DATA_WIDTH-1:0] r_rgb_hold;

    assign w_rd_in   = in_win(iReadRow, iReadCol);
    assign w_rd_addr = w_rd_in ? lin_addr(iReadRow, iReadCol) : '0;
    assign w_wr_in   = in_win(iWriteRow, iWriteCol);
    assign w_wr_addr = w_wr_in ? lin_addr(iWriteRow, iWriteCol) : '0;

    assign oWriteReady = !oBusy;
    assign w_user_we   = iWriteValid && oWriteReady && w_wr_in;

`ifdef WINDOW_CLEAR_EN
    localparam logic [LP_AW-1:0] LP_LAST = LP_AW'(LP_DEPTH - 1);

    clr_state_t       r_state;
    clr_state_t       w_next;
    logic [LP_AW-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) begin
                r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (iClear) w_next = ST_CLEAR;
            ST_CLEAR: if (r_cnt == LP_LAST) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign oBusy      = (r_state == ST_CLEAR);
    assign w_clr_we   = oBusy;
    assign w_clr_addr = r_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = iClear;
    assign oBusy          = 1'b0;
    assign w_clr_we       = 1'b0;
    assign w_clr_addr     = '0;
`endif

    // Clear owns the write port; user writes are blocked while busy
    assign w_ram_we    = w_clr_we || w_user_we;
    assign w_ram_waddr = w_clr_we ? w_clr_addr : w_wr_addr;
    assign w_ram_wdata = w_clr_we ? LP_BG : iRGB;

    video_window_ram #(
        .DW    (DATA_WIDTH),
        .DEPTH (LP_DEPTH),
        .AW    (LP_AW)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (iReadValid),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_valid <= 1'b0;
            r_rd_in    <= 1'b0;
            r_rgb_hold <= LP_BG;
        end else begin
            r_rd_valid <= iReadValid;
            if (iReadValid) begin
                r_rd_in <= w_rd_in;
            end
            if (r_rd_valid) begin
                r_rgb_hold <= w_rd_pix;
            end
        end
    end

    assign w_rd_pix  = r_rd_in ? w_ram_q : LP_BG;
    assign oRGBValid = r_rd_valid;
    assign oRGB      = r_rd_valid ? w_rd_pix : r_rgb_hold;

endmodule

// File: tb/tb_video_window_buffer.sv
// Randomized bench for video_window_buffer against a pixel-array model;
// clear scenarios run when WINDOW_CLEAR_EN is defined.
module tb_video_window_buffer;

    localparam int DW = 3;
    localparam int AW = 10;
    localparam int R0 = 190;
    localparam int C0 = 270;
    localparam int NR = 100;
    localparam int NC = 100;
    localparam int N  = NR * NC;
    localparam logic [DW-1:0] BG = 3'd0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_v = 1'b0;
    logic [AW-1:0] rd_r = '0;
    logic [AW-1:0] rd_c = '0;
    logic          o_v;
    logic [DW-1:0] o_rgb;
    logic          wr_v = 1'b0;
    logic [AW-1:0] wr_r = '0;
    logic [AW-1:0] wr_c = '0;
    logic [DW-1:0] wr_d = '0;
    logic          o_wrdy;
    logic          clr = 1'b0;
    logic          o_busy;

    int n_checks = 0;
    int n_errors = 0;

    video_window_buffer dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .iReadValid  (rd_v),
        .iReadRow    (rd_r),
        .iReadCol    (rd_c),
        .oRGBValid   (o_v),
        .oRGB        (o_rgb),
        .iWriteValid (wr_v),
        .iWriteRow   (wr_r),
        .iWriteCol   (wr_c),
        .iRGB        (wr_d),
        .oWriteReady (o_wrdy),
        .iClear      (clr),
        .oBusy       (o_busy)
    );

    always #5 clk = ~clk;

    // ---- reference model: a plain pixel array plus a clear position ----
    logic [DW-1:0] mem [N];
    logic          m_v;
    logic [DW-1:0] m_rgb;
    int            m_clr;

    function automatic bit inwin(input int r, input int c);
        return r >= R0 && r < R0 + NR && c >= C0 && c < C0 + NC;
    endfunction

    function automatic int fillv(input int a);
        return (a % 7) + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v   = 1'b0;
            m_rgb = BG;
            m_clr = -1;
        end else begin
            m_v = rd_v;
            if (rd_v) begin
                if (inwin(int'(rd_r), int'(rd_c)))
                    m_rgb = mem[(int'(rd_r) - R0) * NC + int'(rd_c) - C0];
                else
                    m_rgb = BG;
            end
            if (wr_v && m_clr < 0 && inwin(int'(wr_r), int'(wr_c)))
                mem[(int'(wr_r) - R0) * NC + int'(wr_c) - C0] = wr_d;
            if (m_clr >= 0) begin
                mem[m_clr] = BG;
                m_clr++;
                if (m_clr == N) m_clr = -1;
            end
`ifdef WINDOW_CLEAR_EN
            else if (clr) begin
                m_clr = 0;
            end
`endif
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(o_v), int'(m_v));
            chk("rgb", int'(o_rgb), int'(m_rgb));
            chk("busy", int'(o_busy), int'(m_clr >= 0));
            chk("wready", int'(o_wrdy), int'(m_clr < 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_v = 1'b0;
        wr_v = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic set_rd(input int r, input int c);
        rd_v = 1'b1;
        rd_r = AW'(r);
        rd_c = AW'(c);
    endtask

    task automatic set_wr(input int r, input int c, input int d);
        wr_v = 1'b1;
        wr_r = AW'(r);
        wr_c = AW'(c);
        wr_d = DW'(d);
    endtask

    task automatic fill_window();
        for (int a = 0; a < N; a++) begin
            idle();
            set_wr(R0 + a / NC, C0 + a % NC, fillv(a));
            if (a > 0 && $urandom_range(0, 3) == 0) begin
                int b;
                b = int'($urandom_range(0, a - 1));
                set_rd(R0 + b / NC, C0 + b % NC);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic rd_addr(input int a);
        idle();
        set_rd(R0 + a / NC, C0 + a % NC);
        tick();
        idle();
    endtask

    initial begin
        idle();
        repeat (3) tick();
        chk("rst_valid", int'(o_v), 0);
        chk("rst_rgb", int'(o_rgb), int'(BG));
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_wready", int'(o_wrdy), 1);
        rst_n = 1'b1;
        tick();

        // corner write / read-back
        set_wr(190, 270, 5); tick();
        idle(); set_rd(190, 270); tick();
        chk("p37_valid", int'(o_v), 1);
        chk("p37_rgb", int'(o_rgb), 5);
        idle(); tick();
        chk("hold_valid", int'(o_v), 0);
        chk("hold_rgb", int'(o_rgb), 5);

        // far corner and just-outside neighbours
        set_wr(289, 369, 3); tick();
        idle(); set_wr(290, 369, 6); tick();
        idle(); set_wr(289, 370, 6); tick();
        idle(); set_rd(289, 369); tick();
        chk("p38_in", int'(o_rgb), 3);
        idle(); set_rd(290, 369); tick();
        chk("p38_row_out", int'(o_rgb), int'(BG));
        idle(); set_rd(289, 370); tick();
        chk("p38_col_out", int'(o_rgb), int'(BG));
        idle(); set_rd(289, 369); tick();
        chk("p38_kept", int'(o_rgb), 3);

        // off-window write completes handshake but is dropped
        idle(); set_wr(100, 100, 7);
        #1 chk("p39_ready", int'(o_wrdy), 1);
        tick();
        idle(); set_rd(100, 100); tick();
        chk("p39_rgb", int'(o_rgb), int'(BG));

        // same-cycle read/write returns old data
        idle(); set_wr(200, 300, 1); tick();
        idle(); set_wr(200, 300, 2); set_rd(200, 300); tick();
        chk("p40_old", int'(o_rgb), 1);
        idle(); set_rd(200, 300); tick();
        chk("p40_new", int'(o_rgb), 2);
        idle(); tick();

        fill_window();

        // randomized mix; coordinates biased around the window edges
        for (int i = 0; i < 3000; i++) begin
            int sel;
            idle();
            sel = int'($urandom_range(0, 9));
            if ($urandom_range(0, 2) != 0) begin
                if (sel == 0)
                    set_rd(int'($urandom_range(0, 1023)),
                           int'($urandom_range(0, 1023)));
                else
                    set_rd(int'($urandom_range(185, 295)),
                           int'($urandom_range(265, 375)));
            end
            if ($urandom_range(0, 2) == 0) begin
                if (sel == 1 && rd_v)
                    set_wr(int'(rd_r), int'(rd_c),
                           int'($urandom_range(0, 7)));
                else
                    set_wr(int'($urandom_range(185, 295)),
                           int'($urandom_range(265, 375)),
                           int'($urandom_range(0, 7)));
            end
            tick();
        end
        idle();
        tick();

`ifdef WINDOW_CLEAR_EN
        begin
            int cnt;
            clr = 1'b1; tick();
            clr = 1'b0;
            cnt = 0;
            while (o_busy && cnt < 20000) begin
                idle();
                if ($urandom_range(0, 1) == 0)
                    set_wr(int'($urandom_range(190, 289)),
                           int'($urandom_range(270, 369)), 7);
                if ($urandom_range(0, 3) == 0)
                    set_rd(int'($urandom_range(190, 289)),
                           int'($urandom_range(270, 369)));
                if ($urandom_range(0, 50) == 0) clr = 1'b1;
                tick();
                cnt++;
            end
            idle();
            chk("clr_len", cnt, N);
            for (int k = 0; k < 40; k++) begin
                rd_addr(int'($urandom_range(0, N - 1)));
                chk("clr_bg", int'(o_rgb), int'(BG));
            end
            tick();
        end

        fill_window();
        clr = 1'b1; tick();
        idle();
        repeat (5000) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_valid", int'(o_v), 0);
        chk("mid_rgb", int'(o_rgb), int'(BG));
        chk("mid_busy", int'(o_busy), 0);
        chk("mid_wready", int'(o_wrdy), 1);
        tick();
        rst_n = 1'b1;
        tick();
        rd_addr(4999);
        chk("mid_4999", int'(o_rgb), int'(BG));
        rd_addr(5000);
        chk("mid_5000", int'(o_rgb), fillv(5000));
        for (int k = 0; k < 40; k++) begin
            rd_addr(int'($urandom_range(0, N - 1)));
        end
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_window_buffer.md
VIDEO_WINDOW_BUFFER -- requirements
Module: video_window_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 3: pixel width in bits (RGB).
REQ-002 Parameter ADDR_WIDTH, default 10: width of row/column coordinate ports.
REQ-003 Parameter WIN_ROWS, default 100: window height in pixels.
REQ-004 Parameter WIN_COLS, default 100: window width in pixels.
REQ-005 Parameter ORIGIN_ROW, default 190: screen row of window top edge.
REQ-006 Parameter ORIGIN_COL, default 270: screen column of window left edge.
REQ-007 Parameter BG_COLOR, default 0: pixel value returned outside the window and used for clear fill.
REQ-008 CLK  input  1  the single clock; all state on rising edge.
REQ-009 RESET_N  input  1  reset, asynchronous, active-low.
REQ-010 iReadValid  input  1  read request strobe.
REQ-011 iReadRow, iReadCol  input  ADDR_WIDTH each  screen read coordinates.
REQ-012 oRGBValid  output  1  oRGB holds the result of the request made one cycle earlier.
REQ-013 oRGB  output  DATA_WIDTH  read pixel.
REQ-014 iWriteValid  input  1  write request; transfer occurs when iWriteValid and oWriteReady are both high.
REQ-015 iWriteRow, iWriteCol  input  ADDR_WIDTH each  screen write coordinates.
REQ-016 iRGB  input  DATA_WIDTH  write pixel.
REQ-017 oWriteReady  output  1  write accepted this cycle when high.
REQ-018 iClear  input  1  single-cycle clear request (only with WINDOW_CLEAR_EN).
REQ-019 oBusy  output  1  clear in progress.

Function
REQ-020 Storage SHALL be WIN_ROWS*WIN_COLS words; linear address = (row-ORIGIN_ROW)*WIN_COLS + (col-ORIGIN_COL), width $clog2(WIN_ROWS*WIN_COLS).
REQ-021 In-window SHALL mean ORIGIN_ROW <= row < ORIGIN_ROW+WIN_ROWS and ORIGIN_COL <= col < ORIGIN_COL+WIN_COLS (half-open); comparison at full ADDR_WIDTH, no truncation.
REQ-022 Read latency SHALL be exactly 1 cycle: oRGBValid = registered iReadValid; oRGB = stored word if in-window, else BG_COLOR.
REQ-023 oRGB SHALL hold its last value while oRGBValid is low.
REQ-024 Out-of-window writes SHALL be accepted (handshake completes) and discarded without modifying storage.
REQ-025 Read and write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-026 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on iClear; CLEAR writes BG_COLOR to address n in cycle n, n = 0..WIN_ROWS*WIN_COLS-1; CLEAR->IDLE after last address.
REQ-027 oBusy SHALL be high exactly while in CLEAR; oWriteReady = !oBusy.
REQ-028 A write handshaked in the same cycle iClear is sampled SHALL be performed and then overwritten by the clear.
REQ-029 iClear while in CLEAR SHALL be ignored (no restart).
REQ-030 Reads SHALL remain serviced during CLEAR; in-window reads return old or BG_COLOR depending on clear progress.

Reset
REQ-031 On RESET_N low: oRGBValid=0, oRGB=BG_COLOR, oBusy=0, oWriteReady=1, FSM=IDLE, clear counter=0.
REQ-032 Storage contents SHALL NOT be reset; reset mid-clear aborts the clear, leaving contents partially cleared.

Configuration
REQ-033 Macro WINDOW_CLEAR_EN defined: clear FSM, iClear and oBusy present per REQ-026..030.
REQ-034 Macro WINDOW_CLEAR_EN undefined: no FSM or counter; iClear ignored, oBusy tied 0, oWriteReady tied 1.

Structure
REQ-035 Shared package video_pkg SHALL hold screen constants (640x480), default DATA_WIDTH, BG_COLOR default and the clear FSM state typedef.
REQ-036 Sub-module video_window_ram: simple dual-port synchronous RAM (1 write, 1 registered read, read-old-data); the window check, address mapping and FSM remain in the top.

Verification
REQ-037 Write (190,270)=3'b101, read (190,270) next cycle -> oRGBValid=1, oRGB=3'b101 one cycle after request.
REQ-038 Write (289,369)=3'b011 then read it -> 3'b011; read (290,369) and (289,370) -> BG_COLOR, storage unchanged.
REQ-039 Write (100,100)=3'b111 -> handshake completes, no storage change; read (100,100) -> BG_COLOR.
REQ-040 Same-cycle write 3'b010 and read at (200,300) holding 3'b001 -> read returns 3'b001, next read 3'b010.
REQ-041 With WINDOW_CLEAR_EN: fill window, pulse iClear -> oBusy high exactly 10000 cycles, oWriteReady low throughout, all reads afterward BG_COLOR.
REQ-042 Assert RESET_N low at clear cycle 5000 -> outputs at reset values immediately, oBusy=0; addresses <5000 read BG_COLOR, >=5000 keep old data.
